// File: rtl/alu_execute_unit.sv
// -----------------------------------------------------------------------------
// alu_execute_unit
//
// Execute stage of the 8-bit datapath. It accepts one operation per Start
// (while not Busy) and computes the result. It then drives the register file
// write port for exactly one cycle. ALU operations take one cycle. The
// optional shift-add multiplier takes nine cycles.
//
// Build option:
//   ALU_MUL_EN  defined   -> opcode 111 is a 9-cycle unsigned multiply
//                            (MULT state, bit counter and accumulator present)
//               undefined -> opcode 111 is MOV (result = OperandB, Carry = 0),
//                            single-cycle like every other opcode
//
// Ports:
//   CLK          clock, all state changes on posedge
//   Reset        synchronous, active-high reset; aborts any operation
//   Start        request, sampled only while Busy = 0
//   Opcode       000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                101 SHL, 110 SHR, 111 MUL / MOV
//   OperandA/B   register file read data, captured at acceptance
//   DestAddress  destination register, captured at acceptance
//   Busy         high while an accepted operation is in flight
//   WriteEnable  one-cycle register file write strobe
//   WriteAddress register file write address (holds after the strobe)
//   WriteData    result (holds after the strobe)
//   Done         copy of WriteEnable for the control unit
//   Zero         result == 0, updated on entry to WRITE
//   Carry        carry / borrow / last shift-out / multiply overflow
// -----------------------------------------------------------------------------
module alu_execute_unit #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic [DATA_WIDTH-1:0]   OperandA,
    input  logic [DATA_WIDTH-1:0]   OperandB,
    input  logic [ADDR_WIDTH-1:0]   DestAddress,
    output logic                    Busy,
    output logic                    WriteEnable,
    output logic [ADDR_WIDTH-1:0]   WriteAddress,
    output logic [DATA_WIDTH-1:0]   WriteData,
    output logic                    Done,
    output logic                    Zero,
    output logic                    Carry
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(7);  // MOV without ALU_MUL_EN

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, WRITE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd2} state_t;
`endif

    state_t state, state_next;
    logic   accept;

    // ---------------------------------------------------------------------
    // Single-cycle ALU, evaluated directly on the inputs so the result can be
    // registered at the same edge that accepts the request.
    // ---------------------------------------------------------------------
    logic [SH_W-1:0]         sh_amt;
    logic [2*DATA_WIDTH-1:0] shl_ext;
    logic [2*DATA_WIDTH-1:0] shr_ext;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_carry;

    assign sh_amt  = OperandB[SH_W-1:0];
    // The last bit shifted out always lands just outside the kept byte:
    // bit DATA_WIDTH for a left shift, bit DATA_WIDTH-1 for a right shift.
    // Both are 0 when the shift amount is 0.
    assign shl_ext = {{DATA_WIDTH{1'b0}}, OperandA} << sh_amt;
    assign shr_ext = {OperandA, {DATA_WIDTH{1'b0}}} >> sh_amt;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
        alu_result = '0;
        alu_carry  = 1'b0;
        case (Opcode)
            OP_ADD: {alu_carry, alu_result} = {1'b0, OperandA} + {1'b0, OperandB};
            // The ninth bit of a wrapped unsigned difference is the borrow.
            OP_SUB: {alu_carry, alu_result} = {1'b0, OperandA} - {1'b0, OperandB};
            OP_AND: alu_result = OperandA & OperandB;
            OP_OR:  alu_result = OperandA | OperandB;
            OP_XOR: alu_result = OperandA ^ OperandB;
            OP_SHL: begin
                alu_result = shl_ext[DATA_WIDTH-1:0];
                alu_carry  = shl_ext[DATA_WIDTH];
            end
            OP_SHR: begin
                alu_result = shr_ext[2*DATA_WIDTH-1:DATA_WIDTH];
                alu_carry  = shr_ext[DATA_WIDTH-1];
            end
`ifndef ALU_MUL_EN
            OP_MUL: alu_result = OperandB;
`endif
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    // ---------------------------------------------------------------------
    // Shift-add multiplier: one multiplier bit per cycle over DATA_WIDTH cycles.
    // ---------------------------------------------------------------------
    localparam logic [SH_W-1:0] LAST_BIT = SH_W'(DATA_WIDTH - 1);

    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [SH_W-1:0]         bit_cnt;
    logic [ADDR_WIDTH-1:0]   dest_q;
    logic                    is_mul;

    assign is_mul   = (Opcode == OP_MUL);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

    assign accept = (state == IDLE) && Start;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        Busy        = 1'b0;
        WriteEnable = 1'b0;
        case (state)
            IDLE: begin
`ifdef ALU_MUL_EN
                if (Start) state_next = is_mul ? MULT : WRITE;
`else
                if (Start) state_next = WRITE;
`endif
            end
`ifdef ALU_MUL_EN
            MULT: begin
                Busy = 1'b1;
                if (bit_cnt == LAST_BIT) state_next = WRITE;
            end
`endif
            WRITE: begin
                Busy        = 1'b1;
                WriteEnable = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Done = WriteEnable;

    // ---------------------------------------------------------------------
    // Result, flag and multiplier registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: this design has no storage array, so every register, datapath included, gets a reset value.
        if (Reset) begin
            WriteAddress <= '0;
            WriteData    <= '0;
            Zero         <= 1'b0;
            Carry        <= 1'b0;
`ifdef ALU_MUL_EN
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            bit_cnt      <= '0;
            dest_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register see the pre-edge values of the others.
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                acc     <= '0;
                bit_cnt <= '0;
                mcand   <= {{DATA_WIDTH{1'b0}}, OperandA};
                mplier  <= OperandB;
                dest_q  <= DestAddress;
            end else if (state == MULT) begin
                acc     <= acc_next;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    WriteData    <= acc_next[DATA_WIDTH-1:0];
                    WriteAddress <= dest_q;
                    Zero         <= (acc_next[DATA_WIDTH-1:0] == '0);
                    Carry        <= |acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end else
`endif
            if (accept) begin
                WriteData    <= alu_result;
                WriteAddress <= DestAddress;
                Zero         <= (alu_result == '0);
                Carry        <= alu_carry;
            end
        end
    end

endmodule
